mem_arbiter: RTL and testbench

Two-port arbiter that shares the single word-addressed memory bus (30-bit word address, 32-bit data, 4-bit byte write enables, read enable, one-cycle read latency) between two requesters, e.g. the cpu and a DMA/loader engine. It sits between the requesters and the memory, grants the bus to one owner at a time, and holds that grant across back-to-back transactions up to a burst limit. Read data is routed back to the requester that issued the read, flagged by a per-port valid pulse.

---
 rtl/mem_arbiter_if.sv | 13 +
 rtl/mem_arbiter.sv | 67 ++++++
 tb/tb_mem_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one requester's view of the shared memory bus.
interface mem_arbiter_if;
  logic        req;
  logic [29:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, addr, re, we, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, re, we, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between two requesters with burst-limited grant hold.
// Define MEM_ARBITER_RR_EN for round-robin on simultaneous requests from idle; default is fixed P0 priority.
module mem_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave m0,
  mem_arbiter_if.slave m1,
  output logic [29:0]  mem_addr,
  output logic         mem_re,
  output logic [3:0]   mem_we,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata
);
  typedef enum logic [1:0] {NONE, P0, P1} owner_t;
  owner_t     owner_q, owner_d, both_win;
  logic [7:0] cnt_q, cnt_d;
  logic       last_q, last_d, rp0_q, rp0_d, rp1_q, rp1_d;
  logic       acc0, acc1, at_limit;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      owner_q <= NONE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      rp0_q   <= 1'b0;
      rp1_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rp0_q   <= rp0_d;
      rp1_q   <= rp1_d;
    end
`ifdef MEM_ARBITER_RR_EN
  assign both_win = last_q ? P0 : P1;
`else
  assign both_win = P0;
`endif
  always_comb begin
    acc0      = owner_q == P0 && m0.req;
    acc1      = owner_q == P1 && m1.req;
    // >= so an owner that ran past the limit while the other port was idle still yields
    at_limit  = cnt_q >= 8'(MAX_BURST - 1);
    mem_addr  = acc0 ? m0.addr  : acc1 ? m1.addr  : '0;
    mem_re    = acc0 ? m0.re    : acc1 ? m1.re    : 1'b0;
    mem_we    = acc0 ? m0.we    : acc1 ? m1.we    : '0;
    mem_wdata = acc0 ? m0.wdata : acc1 ? m1.wdata : '0;
    rp0_d     = acc0 && m0.re;
    rp1_d     = acc1 && m1.re;
    owner_d   = owner_q;
    if (owner_q == NONE)
      owner_d = (m0.req && m1.req) ? both_win : m0.req ? P0 : m1.req ? P1 : NONE;
    else if (owner_q == P0)
      owner_d = !m0.req ? (m1.req ? P1 : NONE) : (at_limit && m1.req) ? P1 : P0;
    else if (owner_q == P1)
      owner_d = !m1.req ? (m0.req ? P0 : NONE) : (at_limit && m0.req) ? P0 : P1;
    cnt_d  = owner_d != owner_q ? '0 : ((acc0 || acc1) && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    last_d = (owner_q != NONE && owner_d != owner_q) ? owner_q == P1 : last_q;
  end
  assign m0.gnt    = owner_q == P0;
  assign m1.gnt    = owner_q == P1;
  assign m0.rvalid = rp0_q;
  assign m1.rvalid = rp1_q;
  assign m0.rdata  = mem_rdata;
  assign m1.rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter built with MAX_BURST=4.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] mem_addr;
  logic        mem_re;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [3:0]  st;
  logic [66:0] memv;
  int          n_cmp = 0;
  int          n_err = 0;
  mem_arbiter_if m0_if();
  mem_arbiter_if m1_if();
  mem_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  assign st   = {m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid};
  assign memv = {mem_addr, mem_re, mem_we, mem_wdata};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    m0_if.req = 0; m0_if.addr = '0; m0_if.re = 0; m0_if.we = '0; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.addr = '0; m1_if.re = 0; m1_if.we = '0; m1_if.wdata = '0;
  endtask

  task automatic drive(input int p, input logic [29:0] a, input logic re, input logic [3:0] we, input logic [31:0] wd);
    if (p == 0) begin
      m0_if.req = 1; m0_if.addr = a; m0_if.re = re; m0_if.we = we; m0_if.wdata = wd;
    end else begin
      m1_if.req = 1; m1_if.addr = a; m1_if.re = re; m1_if.we = we; m1_if.wdata = wd;
    end
  endtask

  task automatic test_reset;
    idle();
    mem_rdata = '0;
    tick(); tick();
    n_cmp++; if (st !== 4'b0000) begin n_err++; $display("FAIL reset_status: got %b want %b", st, 4'b0000); end
    n_cmp++; if (memv !== 67'h0) begin n_err++; $display("FAIL reset_mem: got %h want %h", memv, 67'h0); end
    reset = 1;
    tick();
    n_cmp++; if (st !== 4'b0000) begin n_err++; $display("FAIL post_reset_status: got %b want %b", st, 4'b0000); end
  endtask

  task automatic test_single_read;
    drive(0, 30'h10, 1'b1, 4'h0, 32'h0);
    #1;
    n_cmp++; if (st !== 4'b0000) begin n_err++; $display("FAIL read_pre_gnt: got %b want %b", st, 4'b0000); end
    tick();
    n_cmp++; if (st !== 4'b1000) begin n_err++; $display("FAIL read_gnt: got %b want %b", st, 4'b1000); end
    n_cmp++; if (memv !== {30'h10, 1'b1, 4'h0, 32'h0}) begin n_err++; $display("FAIL read_mem: got %h want %h", memv, {30'h10, 1'b1, 4'h0, 32'h0}); end
    tick();
    idle();
    mem_rdata = 32'hDEADBEEF;
    #1;
    n_cmp++; if (st !== 4'b1010) begin n_err++; $display("FAIL read_rvalid: got %b want %b", st, 4'b1010); end
    n_cmp++; if (m0_if.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_rdata: got %h want %h", m0_if.rdata, 32'hDEADBEEF); end
    n_cmp++; if (memv !== 67'h0) begin n_err++; $display("FAIL read_mem_after: got %h want %h", memv, 67'h0); end
    tick();
    n_cmp++; if (st !== 4'b0000) begin n_err++; $display("FAIL read_release: got %b want %b", st, 4'b0000); end
  endtask

  task automatic test_write;
    drive(1, 30'h3FFFFFFF, 1'b0, 4'b0011, 32'h0000ABCD);
    tick();
    n_cmp++; if (st !== 4'b0100) begin n_err++; $display("FAIL write_gnt: got %b want %b", st, 4'b0100); end
    n_cmp++; if (memv !== {30'h3FFFFFFF, 1'b0, 4'b0011, 32'h0000ABCD}) begin n_err++; $display("FAIL write_mem: got %h want %h", memv, {30'h3FFFFFFF, 1'b0, 4'b0011, 32'h0000ABCD}); end
    tick();
    idle();
    #1;
    n_cmp++; if (memv !== 67'h0) begin n_err++; $display("FAIL write_one_cycle: got %h want %h", memv, 67'h0); end
    n_cmp++; if (st !== 4'b0100) begin n_err++; $display("FAIL write_no_rvalid: got %b want %b", st, 4'b0100); end
    tick();
    n_cmp++; if (st !== 4'b0000) begin n_err++; $display("FAIL write_release: got %b want %b", st, 4'b0000); end
  endtask

  task automatic test_arbitration;
    logic [3:0] want;
`ifdef MEM_ARBITER_RR_EN
    want = 4'b0100;
`else
    want = 4'b1000;
`endif
    drive(0, 30'h5, 1'b1, 4'h0, 32'h0);
    tick(); tick();
    idle();
    tick();
    drive(0, 30'h1, 1'b1, 4'h0, 32'h0);
    drive(1, 30'h2, 1'b1, 4'h0, 32'h0);
    #1;
    n_cmp++; if (st !== 4'b0000) begin n_err++; $display("FAIL arb_idle: got %b want %b", st, 4'b0000); end
    tick();
    n_cmp++; if (st !== want) begin n_err++; $display("FAIL arb_winner: got %b want %b", st, want); end
    idle();
    tick(); tick();
    n_cmp++; if (st !== 4'b0000) begin n_err++; $display("FAIL arb_release: got %b want %b", st, 4'b0000); end
  endtask

  task automatic test_back_to_back;
    logic g0, pv0, pv1;
    logic [3:0]  want;
    logic [66:0] want_mem;
    drive(0, 30'h100, 1'b1, 4'h0, 32'h0);
    drive(1, 30'h200, 1'b1, 4'h0, 32'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      g0  = ((i / 4) % 2) == 0;
      pv0 = i > 0 && (((i - 1) / 4) % 2) == 0;
      pv1 = i > 0 && !pv0;
      want = {g0, !g0, pv0, pv1};
      want_mem = {g0 ? 30'h100 : 30'h200, 1'b1, 4'h0, 32'h0};
      n_cmp++; if (st !== want) begin n_err++; $display("FAIL burst_status[%0d]: got %b want %b", i, st, want); end
      n_cmp++; if (memv !== want_mem) begin n_err++; $display("FAIL burst_mem[%0d]: got %h want %h", i, memv, want_mem); end
      tick();
    end
    idle();
    tick(); tick();
    n_cmp++; if (st !== 4'b0000) begin n_err++; $display("FAIL burst_release: got %b want %b", st, 4'b0000); end
  endtask

  task automatic test_drop_idle;
    drive(0, 30'h7, 1'b0, 4'b1111, 32'h55);
    tick();
    n_cmp++; if (st !== 4'b1000) begin n_err++; $display("FAIL drop_gnt: got %b want %b", st, 4'b1000); end
    tick();
    idle();
    #1;
    n_cmp++; if (memv !== 67'h0) begin n_err++; $display("FAIL drop_mem_gated: got %h want %h", memv, 67'h0); end
    tick();
    n_cmp++; if (st !== 4'b0000) begin n_err++; $display("FAIL drop_none: got %b want %b", st, 4'b0000); end
    n_cmp++; if (memv !== 67'h0) begin n_err++; $display("FAIL drop_none_mem: got %h want %h", memv, 67'h0); end
    drive(1, 30'h9, 1'b1, 4'h0, 32'h0);
    #1;
    n_cmp++; if (st !== 4'b0000) begin n_err++; $display("FAIL other_pre_gnt: got %b want %b", st, 4'b0000); end
    tick();
    n_cmp++; if (st !== 4'b0100) begin n_err++; $display("FAIL other_gnt: got %b want %b", st, 4'b0100); end
    n_cmp++; if (memv !== {30'h9, 1'b1, 4'h0, 32'h0}) begin n_err++; $display("FAIL other_mem: got %h want %h", memv, {30'h9, 1'b1, 4'h0, 32'h0}); end
    idle();
    tick(); tick();
  endtask

  task automatic test_async_reset;
    drive(0, 30'h3, 1'b1, 4'h0, 32'h0);
    tick();
    n_cmp++; if (st !== 4'b1000) begin n_err++; $display("FAIL ar_gnt: got %b want %b", st, 4'b1000); end
    tick();
    mem_rdata = 32'hCAFEF00D;
    #1;
    n_cmp++; if (st !== 4'b1010) begin n_err++; $display("FAIL ar_rvalid: got %b want %b", st, 4'b1010); end
    reset = 0;
    #1;
    n_cmp++; if (st !== 4'b0000) begin n_err++; $display("FAIL ar_immediate: got %b want %b", st, 4'b0000); end
    n_cmp++; if (memv !== 67'h0) begin n_err++; $display("FAIL ar_mem_immediate: got %h want %h", memv, 67'h0); end
    tick();
    n_cmp++; if (memv !== 67'h0) begin n_err++; $display("FAIL ar_mem_held: got %h want %h", memv, 67'h0); end
    idle();
    reset = 1;
    tick();
    n_cmp++; if (st !== 4'b0000) begin n_err++; $display("FAIL ar_after_status: got %b want %b", st, 4'b0000); end
    n_cmp++; if (memv !== 67'h0) begin n_err++; $display("FAIL ar_after_mem: got %h want %h", memv, 67'h0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_arbitration();
    test_back_to_back();
    test_drop_idle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
